// File: rtl/plab4_net_router_output_ctrl_tdm_sep_pkg.sv
// Shared router definitions: port indices, security-domain encoding and width helpers
// used by the TDM-separated output controller and its arbiter.
package plab4_net_router_output_ctrl_tdm_sep_pkg;

  localparam int ROUTE_PREV = 0;
  localparam int ROUTE_TERM = 1;
  localparam int ROUTE_NEXT = 2;
  localparam int NUM_PORTS  = 3;

  typedef enum logic {
    DOMAIN_0 = 1'b0,
    DOMAIN_1 = 1'b1
  } domain_e;

  // Bits needed to hold the values 0..n inclusive (credit counter width).
  function automatic int credit_nbits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_tdm_sep_rr_arb3.sv
// Combinational 3-input round-robin arbiter: the first request found scanning
// ptr, ptr+1, ptr+2 (mod 3) wins; idx is 0 when nothing is granted.
module plab4_net_RoundRobinArb3
  import plab4_net_router_output_ctrl_tdm_sep_pkg::*;
(
  input  logic [2:0] reqs,
  input  logic [1:0] ptr,
  output logic [2:0] grants,
  output logic [1:0] idx
);

  always_comb begin
    // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
    grants = '0;
    idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int i;
      i = (int'(ptr) + k) % NUM_PORTS;
      if (grants == '0 && reqs[i]) begin
        grants[i] = 1'b1;
        idx       = 2'(i);
      end
    end
  end

endmodule

// File: rtl/plab4_net_router_output_ctrl_tdm_sep.sv
// Per-output-port controller: round-robin arbitration restricted to the active TDM
// security domain, downstream credit tracking and the domain slot counter.
module plab4_net_router_output_ctrl_tdm_sep
  import plab4_net_router_output_ctrl_tdm_sep_pkg::*;
#(
  parameter int p_num_credits    = 2,
  parameter int p_num_free_nbits = 2,
  parameter int p_slot_len       = 4,
  parameter int p_tdm_en         = 1
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reqs_p0,
  input  logic                        reqs_p1,
  input  logic                        reqs_p2,
  input  logic                        domain_p0,
  input  logic                        domain_p1,
  input  logic                        domain_p2,
  output logic                        grants_p0,
  output logic                        grants_p1,
  output logic                        grants_p2,
  output logic [1:0]                  xbar_sel,
  output logic                        out_val,
  input  logic                        out_rdy,
  input  logic                        credit_ret,
  output logic [p_num_free_nbits-1:0] num_free,
  output logic                        slot_domain
);

  localparam int c_cnt_nbits = clog2_min1(p_slot_len);
  localparam logic [p_num_free_nbits-1:0] c_max_free = p_num_free_nbits'(p_num_credits);
  localparam logic [c_cnt_nbits-1:0]      c_last_slot = c_cnt_nbits'(p_slot_len - 1);

  logic [1:0]             rr_ptr;
  logic [c_cnt_nbits-1:0] slot_cnt;
  logic [2:0]             reqs;
  logic [2:0]             domains;
  logic [2:0]             eligible;
  logic [2:0]             arb_grants;
  logic [1:0]             arb_idx;
  logic                   can_grant;
  logic                   xfer;

  assign reqs    = {reqs_p2, reqs_p1, reqs_p0};
  assign domains = {domain_p2, domain_p1, domain_p0};

  // Only the active-slot domain may compete, so the other domain cannot perturb grant timing.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = reqs[i] & ((p_tdm_en == 0) || (domains[i] == slot_domain));
    end
  end

  assign can_grant = !reset && (num_free != '0) && out_rdy;

  plab4_net_RoundRobinArb3 u_arb (
    .reqs   (eligible & {3{can_grant}}),
    .ptr    (rr_ptr),
    .grants (arb_grants),
    .idx    (arb_idx)
  );

  assign {grants_p2, grants_p1, grants_p0} = arb_grants;
  assign xbar_sel = arb_idx;
  assign out_val  = |arb_grants;
  assign xfer     = out_val & out_rdy;

  always_ff @(posedge clk) begin
    // NOTE: all control state is reset here; the block has no storage array that would skip reset.
    if (reset) begin
      rr_ptr      <= 2'(ROUTE_PREV);
      num_free    <= c_max_free;
      slot_cnt    <= '0;
      slot_domain <= DOMAIN_0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values of the others.
      if (xfer) begin
        rr_ptr <= (arb_idx == 2'(ROUTE_NEXT)) ? 2'(ROUTE_PREV) : arb_idx + 2'd1;
      end

      if (xfer && !credit_ret) begin
        num_free <= num_free - p_num_free_nbits'(1);
      end else if (credit_ret && !xfer && (num_free != c_max_free)) begin
        num_free <= num_free + p_num_free_nbits'(1);
      end

      if (slot_cnt == c_last_slot) begin
        slot_cnt    <= '0;
        slot_domain <= ~slot_domain;
      end else begin
        slot_cnt <= slot_cnt + c_cnt_nbits'(1);
      end
    end
  end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_tdm_sep.sv
// Self-checking bench: a TDM-enabled and a TDM-disabled controller share stimulus and are
// compared every cycle against a cycle-count based reference model, plus directed scenarios.
module tb_plab4_net_router_output_ctrl_tdm_sep;

  localparam int NC   = 2;
  localparam int SLOT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rq;
  logic [2:0] dm;
  logic       rdy;
  logic       cr;

  logic [2:0] gr_t, gr_n;
  logic [1:0] xs_t, xs_n;
  logic       ov_t, ov_n;
  logic [1:0] nf_t, nf_n;
  logic       sd_t, sd_n;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: index 0 = TDM enabled, 1 = TDM disabled.
  int m_ptr[2];
  int m_free[2];
  int m_cyc;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  plab4_net_router_output_ctrl_tdm_sep #(
    .p_num_credits(NC), .p_num_free_nbits(2), .p_slot_len(SLOT), .p_tdm_en(1)
  ) dut (
    .clk(clk), .reset(reset),
    .reqs_p0(rq[0]), .reqs_p1(rq[1]), .reqs_p2(rq[2]),
    .domain_p0(dm[0]), .domain_p1(dm[1]), .domain_p2(dm[2]),
    .grants_p0(gr_t[0]), .grants_p1(gr_t[1]), .grants_p2(gr_t[2]),
    .xbar_sel(xs_t), .out_val(ov_t), .out_rdy(rdy), .credit_ret(cr),
    .num_free(nf_t), .slot_domain(sd_t)
  );

  plab4_net_router_output_ctrl_tdm_sep #(
    .p_num_credits(NC), .p_num_free_nbits(2), .p_slot_len(SLOT), .p_tdm_en(0)
  ) dut_nt (
    .clk(clk), .reset(reset),
    .reqs_p0(rq[0]), .reqs_p1(rq[1]), .reqs_p2(rq[2]),
    .domain_p0(dm[0]), .domain_p1(dm[1]), .domain_p2(dm[2]),
    .grants_p0(gr_n[0]), .grants_p1(gr_n[1]), .grants_p2(gr_n[2]),
    .xbar_sel(xs_n), .out_val(ov_n), .out_rdy(rdy), .credit_ret(cr),
    .num_free(nf_n), .slot_domain(sd_n)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_slot_domain();
    return (m_cyc / SLOT) % 2;
  endfunction

  function automatic int model_winner(input int t);
    if (reset || m_free[t] == 0 || !rdy) return -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr[t] + k) % 3;
      if (rq[i] && (t == 1 || int'(dm[i]) == model_slot_domain())) return i;
    end
    return -1;
  endfunction

  // One cycle: drive inputs after negedge, compare both DUTs, then advance the model.
  task automatic step(input logic r, input logic [2:0] q, input logic [2:0] d,
                      input logic y, input logic c);
    int w[2];
    @(negedge clk);
    reset = r; rq = q; dm = d; rdy = y; cr = c;
    #1;
    for (int t = 0; t < 2; t++) begin
      int eg;
      w[t] = model_winner(t);
      eg   = (w[t] < 0) ? 0 : (1 << w[t]);
      check(t == 0 ? "tdm_grants" : "nt_grants", int'(t == 0 ? gr_t : gr_n), eg);
      check(t == 0 ? "tdm_xbar_sel" : "nt_xbar_sel", int'(t == 0 ? xs_t : xs_n),
            (w[t] < 0) ? 0 : w[t]);
      check(t == 0 ? "tdm_out_val" : "nt_out_val", int'(t == 0 ? ov_t : ov_n),
            (w[t] < 0) ? 0 : 1);
      if (m_valid) begin
        check(t == 0 ? "tdm_num_free" : "nt_num_free", int'(t == 0 ? nf_t : nf_n), m_free[t]);
        check(t == 0 ? "tdm_slot_domain" : "nt_slot_domain", int'(t == 0 ? sd_t : sd_n),
              model_slot_domain());
      end
    end
    if (r) begin
      for (int t = 0; t < 2; t++) begin
        m_ptr[t]  = 0;
        m_free[t] = NC;
      end
      m_cyc   = 0;
      m_valid = 1'b1;
    end else begin
      for (int t = 0; t < 2; t++) begin
        bit xf;
        xf = (w[t] >= 0);
        if (xf) m_ptr[t] = (w[t] + 1) % 3;
        if (xf && !c) m_free[t]--;
        else if (c && !xf && m_free[t] < NC) m_free[t]++;
      end
      m_cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; rq = '0; dm = '0; rdy = 1'b0; cr = 1'b0;

    // Reset then a single p0 request in domain 0.
    step(1, 3'b000, 3'b000, 1, 0);
    step(0, 3'b001, 3'b000, 1, 0);
    check("t1_grant_p0", int'(gr_t), 1);
    check("t1_xbar_sel", int'(xs_t), 0);
    step(0, 3'b000, 3'b000, 1, 0);
    check("t1_num_free", int'(nf_t), 1);

    // Continuous contention with credit return: non-TDM controller rotates p0,p1,p2.
    step(1, 3'b000, 3'b000, 1, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 3'b111, 3'b000, 1, 1);
      check("t2_rr_winner", int'(xs_n), k % 3);
      check("t2_rr_grant", int'(gr_n), 1 << (k % 3));
    end

    // Credit exhaustion then resume on credit_ret.
    step(1, 3'b000, 3'b000, 1, 0);
    step(0, 3'b001, 3'b000, 1, 0);
    step(0, 3'b001, 3'b000, 1, 0);
    step(0, 3'b001, 3'b000, 1, 1);
    check("t3_empty_grant", int'(gr_t), 0);
    check("t3_empty_free", int'(nf_t), 0);
    step(0, 3'b001, 3'b000, 1, 0);
    check("t3_resume_free", int'(nf_t), 1);
    check("t3_resume_grant", int'(gr_t), 1);

    // Domain-1 requester waits for its slot.
    step(1, 3'b000, 3'b000, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 3'b100, 3'b100, 1, 0);
      check("t4_grant_p2", int'(gr_t), (k < 4) ? 0 : 4);
    end
    check("t4_slot_domain", int'(sd_t), 1);

    // Simultaneous transfer and credit return; saturation at full.
    step(1, 3'b000, 3'b000, 1, 0);
    step(0, 3'b001, 3'b000, 1, 0);
    step(0, 3'b001, 3'b000, 1, 1);
    step(0, 3'b000, 3'b000, 1, 1);
    check("t5_xfer_and_ret", int'(nf_t), 1);
    step(0, 3'b000, 3'b000, 1, 1);
    check("t5_ret_to_full", int'(nf_t), 2);
    step(0, 3'b000, 3'b000, 1, 0);
    check("t5_saturate", int'(nf_t), 2);

    // Reset during contention once rr_ptr has advanced to 2.
    step(1, 3'b000, 3'b000, 1, 0);
    step(0, 3'b111, 3'b000, 1, 1);
    step(0, 3'b111, 3'b000, 1, 1);
    step(1, 3'b111, 3'b000, 1, 1);
    check("t6_grant_in_reset", int'(gr_t), 0);
    step(0, 3'b111, 3'b000, 1, 1);
    check("t6_ptr_reset", int'(xs_t), 0);
    check("t6_free_reset", int'(nf_t), 2);
    check("t6_slot_reset", int'(sd_t), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), 3'($urandom), 3'($urandom),
           ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
